// File: rtl/inst_fetch_unit.sv
// Instruction fetch sequencer: it holds the PC, fetches one word at a time over
// imem req/ack, presents it until retire, then steps to PC+4 or to the branch target.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSel,
  input  logic [31:0] alu_target,
  input  logic        retire,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err,
  output logic [31:0] retired_cnt,
  output logic [1:0]  fsm_state
);

  // Handshake: the memory may take the read on any cycle where imem_req=1 and
  // imem_ack=1; imem_addr stays constant from req rise until that cycle, and
  // imem_ack is ignored whenever imem_req=0.

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        req_q, req_d;
  logic        misalign_q, misalign_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] next_pc;

  // Bit 0 of the target is dropped as jalr requires.
  assign next_pc = PCSel ? (alu_target & ~32'd1) : (pc_q + 32'd4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b1;
      misalign_q   <= 1'b0;
      cnt_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_q        <= req_d;
      misalign_q   <= misalign_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    req_d        = req_q;
    misalign_d   = misalign_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          req_d        = 1'b0;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (retire) begin
          cnt_d        = cnt_q + 32'd1;
          inst_valid_d = 1'b0;
          if (!next_pc[1]) begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end
        end
      end
      default: begin
        // HALT (and the unused encoding) freezes everything until reset.
        state_d = S_HALT;
      end
    endcase
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign inst         = inst_q;
  assign inst_valid   = inst_valid_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign misalign_err = misalign_q;
  assign retired_cnt  = cnt_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, zero-wait and wait-state fetch,
// branch/jalr/misalign, spurious inputs, PC wrap and mid-fetch reset.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PCSel;
  logic [31:0] alu_target;
  logic        retire;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
  logic [31:0] retired_cnt;
  logic [1:0]  fsm_state;

  // Second instance for the PC wrap case
  logic        w_rst, w_PCSel, w_retire, w_imem_req, w_imem_ack, w_inst_valid, w_misalign_err;
  logic [31:0] w_alu_target, w_imem_addr, w_imem_rdata, w_inst, w_pc, w_pc_plus4, w_retired_cnt;
  logic [1:0]  w_fsm_state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] ST_FETCH = 2'd0, ST_HOLD = 2'd1, ST_HALT = 2'd2;

  inst_fetch_unit u_dut (
    .clk(clk), .rst(rst), .PCSel(PCSel), .alu_target(alu_target), .retire(retire),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
    .misalign_err(misalign_err), .retired_cnt(retired_cnt), .fsm_state(fsm_state)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(w_rst), .PCSel(w_PCSel), .alu_target(w_alu_target), .retire(w_retire),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
    .inst(w_inst), .inst_valid(w_inst_valid), .pc(w_pc), .pc_plus4(w_pc_plus4),
    .misalign_err(w_misalign_err), .retired_cnt(w_retired_cnt), .fsm_state(w_fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the memory model returns for an address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0093 | (a << 12);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; retire = 1'b0; PCSel = 1'b0; alu_target = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Serves one fetch at exp_a after `waits` wait states and checks the result.
  task automatic fetch(input logic [31:0] exp_a, input int waits);
    logic [31:0] d;
    d = mem_word(exp_a);
    for (int i = 0; i < waits; i++) begin
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, exp_a})
        $display("FAIL fetch_wait req/addr got %b/%h want 1/%h", imem_req, imem_addr, exp_a);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, exp_a})
      $display("FAIL fetch_req req/addr got %b/%h want 1/%h", imem_req, imem_addr, exp_a);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = d;
    @(posedge clk); #1;
    imem_ack = 1'b0; imem_rdata = $urandom;
    n_checks++;
    if ({inst, inst_valid, imem_req, pc, pc_plus4} !== {d, 1'b1, 1'b0, exp_a, exp_a + 32'd4})
      $display("FAIL fetch_data inst/valid/req/pc/pc4 got %h/%b/%b/%h/%h want %h/1/0/%h/%h",
               inst, inst_valid, imem_req, pc, pc_plus4, d, exp_a, exp_a + 32'd4);
    else n_pass++;
  endtask

  task automatic do_retire(input logic sel, input logic [31:0] tgt);
    retire = 1'b1; PCSel = sel; alu_target = tgt;
    @(posedge clk); #1;
    retire = 1'b0; PCSel = $urandom_range(0, 1); alu_target = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; retire = 1'b0; PCSel = 1'b0; alu_target = 32'd0;
    @(posedge clk); #1;
    n_checks++;
    if ({fsm_state, pc, inst, inst_valid, imem_req, misalign_err, retired_cnt, pc_plus4} !==
        {ST_FETCH, 32'd0, 32'h13, 1'b0, 1'b1, 1'b0, 32'd0, 32'd4})
      $display("FAIL reset_values st/pc/inst/v/req/err/cnt got %0d/%h/%h/%b/%b/%b/%0d want 0/0/13/0/1/0/0",
               fsm_state, pc, inst, inst_valid, imem_req, misalign_err, retired_cnt);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'd0})
      $display("FAIL zw_first_req req/addr got %b/%h want 1/0", imem_req, imem_addr);
    else n_pass++;
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    n_checks++;
    if ({inst, inst_valid, pc_plus4, fsm_state} !== {32'h0050_0093, 1'b1, 32'd4, ST_HOLD})
      $display("FAIL zw_inst inst/valid/pc4/st got %h/%b/%h/%0d want 00500093/1/4/1",
               inst, inst_valid, pc_plus4, fsm_state);
    else n_pass++;
    do_retire(1'b0, 32'h0);
    n_checks++;
    if ({imem_req, imem_addr, inst_valid, retired_cnt} !== {1'b1, 32'd4, 1'b0, 32'd1})
      $display("FAIL zw_retire req/addr/valid/cnt got %b/%h/%b/%0d want 1/4/0/1",
               imem_req, imem_addr, inst_valid, retired_cnt);
    else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4), 3);
      do_retire(1'b0, 32'hDEAD_BEE0);
    end
    n_checks++;
    if ({retired_cnt, pc, imem_req} !== {32'd4, 32'h10, 1'b1})
      $display("FAIL seq_end cnt/pc/req got %0d/%h/%b want 4/10/1", retired_cnt, pc, imem_req);
    else n_pass++;
  endtask

  // Continues from pc=0x10 left by test_sequential.
  task automatic test_branch_jalr_misalign();
    fetch(32'h10, 0);
    do_retire(1'b1, 32'h40);
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40})
      $display("FAIL branch_target req/addr got %b/%h want 1/40", imem_req, imem_addr);
    else n_pass++;
    fetch(32'h40, 1);
    do_retire(1'b1, 32'h101);
    n_checks++;
    if ({imem_req, imem_addr, misalign_err} !== {1'b1, 32'h100, 1'b0})
      $display("FAIL jalr_target req/addr/err got %b/%h/%b want 1/100/0", imem_req, imem_addr, misalign_err);
    else n_pass++;
    fetch(32'h100, 2);
    do_retire(1'b1, 32'h102);
    n_checks++;
    if ({misalign_err, imem_req, pc, fsm_state, inst_valid, retired_cnt} !==
        {1'b1, 1'b0, 32'h100, ST_HALT, 1'b0, 32'd7})
      $display("FAIL misalign err/req/pc/st/valid/cnt got %b/%b/%h/%0d/%b/%0d want 1/0/100/2/0/7",
               misalign_err, imem_req, pc, fsm_state, inst_valid, retired_cnt);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000; retire = 1'b1; PCSel = 1'b1; alu_target = 32'h200;
      @(posedge clk); #1;
      n_checks++;
      if ({misalign_err, imem_req, pc, inst, retired_cnt} !==
          {1'b1, 1'b0, 32'h100, mem_word(32'h100), 32'd7})
        $display("FAIL halt_frozen err/req/pc/inst/cnt got %b/%b/%h/%h/%0d want 1/0/100/%h/7",
                 misalign_err, imem_req, pc, inst, retired_cnt, mem_word(32'h100));
      else n_pass++;
    end
    imem_ack = 1'b0; retire = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    fetch(32'h0, 0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    n_checks++;
    if ({inst, inst_valid, fsm_state, imem_req} !== {mem_word(32'h0), 1'b1, ST_HOLD, 1'b0})
      $display("FAIL spurious_ack inst/valid/st/req got %h/%b/%0d/%b want %h/1/1/0",
               inst, inst_valid, fsm_state, imem_req, mem_word(32'h0));
    else n_pass++;
    do_retire(1'b0, 32'h0);
    retire = 1'b1; PCSel = 1'b1; alu_target = 32'h80;
    @(posedge clk); #1;
    retire = 1'b0;
    n_checks++;
    if ({pc, retired_cnt, imem_req, fsm_state} !== {32'h4, 32'd1, 1'b1, ST_FETCH})
      $display("FAIL spurious_retire pc/cnt/req/st got %h/%0d/%b/%0d want 4/1/1/0",
               pc, retired_cnt, imem_req, fsm_state);
    else n_pass++;
  endtask

  task automatic test_wrap();
    w_rst = 1'b0;
    n_checks++;
    if ({w_imem_req, w_imem_addr, w_pc_plus4} !== {1'b1, 32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap_reset req/addr/pc4 got %b/%h/%h want 1/fffffffc/0", w_imem_req, w_imem_addr, w_pc_plus4);
    else n_pass++;
    w_imem_ack = 1'b1; w_imem_rdata = 32'h0000_0013;
    @(posedge clk); #1;
    w_imem_ack = 1'b0;
    w_retire = 1'b1; w_PCSel = 1'b0;
    @(posedge clk); #1;
    w_retire = 1'b0;
    n_checks++;
    if ({w_imem_req, w_imem_addr, w_misalign_err, w_retired_cnt} !== {1'b1, 32'h0, 1'b0, 32'd1})
      $display("FAIL wrap_next req/addr/err/cnt got %b/%h/%b/%0d want 1/0/0/1",
               w_imem_req, w_imem_addr, w_misalign_err, w_retired_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    fetch(32'h0, 0); do_retire(1'b0, 32'h0);
    fetch(32'h4, 0); do_retire(1'b0, 32'h0);
    @(posedge clk); #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8})
      $display("FAIL mid_waiting req/addr got %b/%h want 1/8", imem_req, imem_addr);
    else n_pass++;
    #2;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    n_checks++;
    if ({fsm_state, pc, inst, inst_valid, imem_req, retired_cnt} !==
        {ST_FETCH, 32'h0, 32'h13, 1'b0, 1'b1, 32'd0})
      $display("FAIL mid_async st/pc/inst/valid/req/cnt got %0d/%h/%h/%b/%b/%0d want 0/0/13/0/1/0",
               fsm_state, pc, inst, inst_valid, imem_req, retired_cnt);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({imem_req, imem_addr, inst_valid, inst} !== {1'b1, 32'h0, 1'b0, 32'h13})
      $display("FAIL mid_after req/addr/valid/inst got %b/%h/%b/%h want 1/0/0/13",
               imem_req, imem_addr, inst_valid, inst);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; PCSel = 1'b0; alu_target = 32'd0; retire = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    w_rst = 1'b1; w_PCSel = 1'b0; w_alu_target = 32'd0; w_retire = 1'b0; w_imem_ack = 1'b0; w_imem_rdata = 32'd0;
    #2;
    test_reset();
    test_zero_wait();
    test_sequential();
    test_branch_jalr_misalign();
    test_spurious();
    test_wrap();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
